rx_pkt_parser: RTL



---
 rtl/rx_pkt_pkg.sv | 51 +++++
 rtl/rx_pkt_parser.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rx_pkt_pkg.sv
// rtl/rx_pkt_pkg.sv - shared type codes, frame lengths and FSM encoding for rx_pkt_parser
package rx_pkt_pkg;

    localparam int WORD_WIDTH = 16;

    // Packet type codes carried in byte0[2:0]
    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_INV  = 3'b010;
    localparam logic [2:0] PKT_CHTS = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;

    // Frame lengths in bytes, including byte0
    localparam logic [3:0] LEN_HB       = 4'd15;
    localparam logic [3:0] LEN_CHE      = 4'd7;
    localparam logic [3:0] LEN_INV      = 4'd7;
    localparam logic [3:0] LEN_CHTS     = 4'd9;
    localparam logic [3:0] LEN_DATA_MIN = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RECV = 3'd1,
        ST_DROP = 3'd2,
        ST_EMIT = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic type_valid(input logic [2:0] t);
        case (t)
            PKT_HB, PKT_CHE, PKT_INV, PKT_CHTS, PKT_DATA: type_valid = 1'b1;
            default:                                      type_valid = 1'b0;
        endcase
    endfunction

    // Exact length for fixed types; minimum length for DATA
    function automatic logic [3:0] frame_len(input logic [2:0] t);
        case (t)
            PKT_HB:   frame_len = LEN_HB;
            PKT_CHE:  frame_len = LEN_CHE;
            PKT_INV:  frame_len = LEN_INV;
            PKT_CHTS: frame_len = LEN_CHTS;
            default:  frame_len = LEN_DATA_MIN;
        endcase
    endfunction

    // The parser takes bytes in every state except the two one-cycle tail states
    function automatic logic state_accepts(input state_t s);
        state_accepts = (s == ST_IDLE) || (s == ST_RECV) || (s == ST_DROP);
    endfunction

endpackage

// File: rtl/rx_pkt_parser.sv
// rtl/rx_pkt_parser.sv - receive frame parser for myNodeInfo; optional stats counters under RX_PKT_STATS_EN
module rx_pkt_parser
    import rx_pkt_pkg::*;
#(
    parameter int BYTE_WIDTH = 8,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  en_MNI,
    output logic [2:0]            fPktType,
    output logic [WORD_WIDTH-1:0] sourceID,
    output logic [WORD_WIDTH-1:0] destinationID,
    output logic [WORD_WIDTH-1:0] hops,
    output logic [WORD_WIDTH-1:0] energy,
    output logic [WORD_WIDTH-1:0] e_max,
    output logic [WORD_WIDTH-1:0] e_min,
    output logic [WORD_WIDTH-1:0] e_threshold,
    output logic [WORD_WIDTH-1:0] timeslot,
    output logic                  pkt_err
`ifdef RX_PKT_STATS_EN
    ,
    output logic [15:0]           rx_ok_cnt,
    output logic [15:0]           rx_drop_cnt
`endif
);

    state_t                state, state_n;
    logic                  in_ready_q;
    logic                  accept;
    logic [3:0]            cnt;
    logic [3:0]            cnt_m1;
    logic [2:0]            widx;
    logic [2:0]            sh_type;
    logic                  is_data;
    logic [3:0]            flen;
    logic                  good_end;
    logic                  over_len;
    logic                  do_write;
    logic [WORD_WIDTH-1:0] sh [0:7];
    logic [WORD_WIDTH-1:0] wm [0:7];

    assign accept   = in_valid & in_ready_q;
    assign in_ready = in_ready_q;
    assign is_data  = (sh_type == PKT_DATA);
    assign flen     = frame_len(sh_type);
    assign good_end = is_data ? (cnt >= 4'd6) : (cnt == flen - 4'd1);
    assign over_len = !is_data && (cnt >= flen);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode: byte0 type check, length tracking, swallow-until-last
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (in_last) begin
                        state_n = ST_ERR;
                    end else if (!type_valid(in_data[2:0])) begin
                        state_n = ST_DROP;
                    end else begin
                        state_n = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (accept) begin
                    if (over_len) begin
                        state_n = in_last ? ST_ERR : ST_DROP;
                    end else if (in_last) begin
                        state_n = good_end ? ST_EMIT : ST_ERR;
                    end
                end
            end
            ST_DROP: begin
                if (accept && in_last) begin
                    state_n = ST_ERR;
                end
            end
            ST_EMIT: state_n = ST_IDLE;
            ST_ERR:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Output decode: strobes come straight from the registered state
    always_comb begin
        en_MNI  = (state == ST_EMIT);
        pkt_err = (state == ST_ERR);
    end

    // Shadow words with the current byte merged in, so the final byte can commit on its own handshake edge
    always_comb begin
        wm       = sh;
        cnt_m1   = cnt - 4'd1;
        widx     = cnt_m1[3:1];
        do_write = (state == ST_RECV) && accept && (cnt <= 4'd14) && (!is_data || cnt <= 4'd6);
        if (do_write) begin
            if (cnt[0]) begin
                wm[widx][WORD_WIDTH-1 -: BYTE_WIDTH] = in_data;
            end else begin
                wm[widx][BYTE_WIDTH-1:0] = in_data;
            end
        end
    end

    // Byte counter, shadow capture and ready flop (ready held low through reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            sh_type    <= 3'd0;
            in_ready_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                sh[i] <= '0;
            end
        end else begin
            in_ready_q <= state_accepts(state_n);
            sh         <= wm;
            if (state == ST_IDLE && accept) begin
                sh_type <= in_data[2:0];
                cnt     <= 4'd1;
            end else if (state == ST_RECV && accept) begin
                if (cnt != 4'hF) begin
                    cnt <= cnt + 4'd1;
                end
            end else if (state == ST_EMIT || state == ST_ERR) begin
                cnt <= 4'd0;
            end
        end
    end

    // Output field commit on a good frame end; fields the type does not carry hold
    always_ff @(posedge clk) begin
        if (rst) begin
            fPktType      <= 3'b111;
            sourceID      <= '0;
            destinationID <= '0;
            hops          <= '0;
            energy        <= '0;
            e_max         <= '0;
            e_min         <= '0;
            e_threshold   <= '0;
            timeslot      <= '0;
        end else if (state_n == ST_EMIT) begin
            fPktType      <= sh_type;
            sourceID      <= wm[0];
            destinationID <= wm[1];
            hops          <= wm[2];
            if (sh_type == PKT_HB) begin
                energy      <= wm[3];
                e_max       <= wm[4];
                e_min       <= wm[5];
                e_threshold <= wm[6];
            end
            if (sh_type == PKT_CHTS) begin
                timeslot <= wm[3];
            end
        end
    end

`ifdef RX_PKT_STATS_EN
    // Saturating good/dropped frame counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ok_cnt   <= 16'd0;
            rx_drop_cnt <= 16'd0;
        end else begin
            if (en_MNI && rx_ok_cnt != 16'hFFFF) begin
                rx_ok_cnt <= rx_ok_cnt + 16'd1;
            end
            if (pkt_err && rx_drop_cnt != 16'hFFFF) begin
                rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
